fetch_branch_unit: RTL and testbench

Instruction-fetch and next-PC control block that drives the program counter's select and offset inputs. It reads the current PC, fetches the 32-bit instruction over a req/ack instruction-memory handshake, and hands it downstream over valid/ready. It decodes the ARMv8 branch class (B, BL, B.cond, CBZ, CBNZ, BR) and issues the matching PC-select code in the cycle the instruction is accepted.

---
 rtl/arm_branch_pkg.sv | 51 +++++
 rtl/fetch_branch_unit_if.sv | 22 ++
 rtl/cond_eval.sv | 35 +++
 rtl/fetch_branch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_branch_unit.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_branch_pkg.sv
// Shared definitions for the fetch/branch slice: FSM states, PC-select codes,
// branch opcode match values, condition codes and sign-extension helpers.
package arm_branch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2
    } fbu_state_t;

    // PC select codes seen by the program counter
    localparam logic [1:0] PS_HOLD = 2'b00;  // keep PC
    localparam logic [1:0] PS_INC  = 2'b01;  // PC + 4
    localparam logic [1:0] PS_LOAD = 2'b10;  // PC <- pc_offset
    localparam logic [1:0] PS_REL  = 2'b11;  // PC <- PC + 4 + pc_offset*4

    // Opcode match values
    localparam logic [5:0]  OP_B     = 6'b000101;                 // [31:26]
    localparam logic [5:0]  OP_BL    = 6'b100101;                 // [31:26]
    localparam logic [7:0]  OP_BCOND = 8'b01010100;               // [31:24]
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;               // [31:24]
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;               // [31:24]
    localparam logic [21:0] OP_BR    = 22'b1101011000011111000000; // [31:10]

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    function automatic logic [63:0] sext26(input logic [25:0] v);
        return {{38{v[25]}}, v};
    endfunction

    function automatic logic [63:0] sext19(input logic [18:0] v);
        return {{45{v[18]}}, v};
    endfunction

endpackage

// File: rtl/fetch_branch_unit_if.sv
// Instruction-memory request/ack bus plus the downstream instruction
// valid/ready bus. master = fetch unit side, slave = memory/consumer side.
interface fetch_branch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: taken=1 when cond holds for the NZCV flags.
module cond_eval
    import arm_branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);
    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    // Full 16-way decode of the condition field
    always_comb begin
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c && !z;
            COND_LS: taken = !(c && !z);
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z && (n == v);
            COND_LE: taken = !(!z && (n == v));
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
            default: taken = 1'b1;
        endcase
    end
endmodule

// File: rtl/fetch_branch_unit.sv
// Fetches one instruction at a time from the current PC, holds it for the
// downstream consumer and, in the cycle it is accepted, drives the PC select
// and offset for the ARMv8 branch class (B, BL, B.cond, CBZ, CBNZ, BR).
//
// Handshakes: imem request is held high for the whole REQ state and a
// transfer happens on a rising edge where imem_req && imem_ack; downstream, a
// transfer happens on a rising edge where instr_valid && instr_ready, and
// instr/instr_pc stay stable while instr_valid is high and instr_ready low.
module fetch_branch_unit
    import arm_branch_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [63:0]                 pc,
    output logic [1:0]                  ps,
    output logic [63:0]                 pc_offset,
    input  logic [3:0]                  flags,
    output logic [4:0]                  rf_addr,
    input  logic [63:0]                 rf_data,
    output logic                        link_we,
    output logic [63:0]                 link_data,
    output fbu_state_t                  state_dbg,
    fetch_branch_unit_if.master         bus
);
    fbu_state_t  state, state_nxt;
    logic [31:0] instr_q;
    logic [63:0] instr_pc_q;
    logic        accept;
    logic        cond_taken;
    logic        is_b, is_bl, is_bcond, is_cb, is_br;

    assign bus.imem_addr = pc;
    assign bus.instr     = instr_q;
    assign bus.instr_pc  = instr_pc_q;
    assign state_dbg     = state;

    assign is_b     = (instr_q[31:26] == OP_B);
    assign is_bl    = (instr_q[31:26] == OP_BL);
    assign is_bcond = (instr_q[31:24] == OP_BCOND) && !instr_q[4];
    assign is_cb    = (instr_q[31:24] == OP_CBZ) || (instr_q[31:24] == OP_CBNZ);
    assign is_br    = (instr_q[31:10] == OP_BR) && (instr_q[4:0] == 5'd0);

    cond_eval u_cond_eval (
        .cond  (instr_q[3:0]),
        .nzcv  (flags),
        .taken (cond_taken)
    );

    // State register; reset drops any in-flight request immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Capture the instruction and its fetch address on the ack edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q    <= 32'd0;
            instr_pc_q <= 64'd0;
        end else if (state == ST_REQ && bus.imem_ack) begin
            instr_q    <= bus.imem_rdata;
            instr_pc_q <= pc;
        end
    end

    // Next state and handshake strobes
    always_comb begin
        state_nxt       = state;
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        accept          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                bus.instr_valid = 1'b1;
                if (bus.instr_ready) begin
                    accept    = 1'b1;
                    state_nxt = enable ? ST_REQ : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Branch decode; the -1 on relative offsets cancels the PC's own +4
    always_comb begin
        ps        = PS_HOLD;
        pc_offset = 64'd0;
        rf_addr   = 5'd0;
        link_we   = 1'b0;
        link_data = 64'd0;
        if (state == ST_EXEC) begin
            link_data = instr_pc_q + 64'd4;
            if (is_cb)      rf_addr = instr_q[4:0];
            else if (is_br) rf_addr = instr_q[9:5];
        end
        if (accept) begin
            ps = PS_INC;
            if (is_b || is_bl) begin
                ps        = PS_REL;
                pc_offset = sext26(instr_q[25:0]) - 64'd1;
                link_we   = is_bl;
            end else if (is_bcond) begin
                if (cond_taken) begin
                    ps        = PS_REL;
                    pc_offset = sext19(instr_q[23:5]) - 64'd1;
                end
            end else if (is_cb) begin
                // bit 24 distinguishes CBNZ from CBZ
                if ((rf_data == 64'd0) != instr_q[24]) begin
                    ps        = PS_REL;
                    pc_offset = sext19(instr_q[23:5]) - 64'd1;
                end
            end else if (is_br) begin
                ps        = PS_LOAD;
                pc_offset = rf_data;
            end
        end
    end
endmodule

// File: tb/tb_fetch_branch_unit.sv
// Bench for fetch_branch_unit: directed cases followed by random instruction
// streams; expected responses are queued at fetch time and compared when the
// downstream accept happens.
module tb_fetch_branch_unit;
    import arm_branch_pkg::*;

    typedef struct packed {
        logic [31:0] w;
        logic [63:0] pc;
        logic [1:0]  ps;
        logic [63:0] nxt;
        logic [63:0] off;
        logic        chk_off;
        logic        link;
        logic [4:0]  ra;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic        clock;
    logic        reset;
    logic        enable;
    logic [63:0] pc;
    logic [1:0]  ps;
    logic [63:0] pc_offset;
    logic [3:0]  flags;
    logic [4:0]  rf_addr;
    logic [63:0] rf_data;
    logic        link_we;
    logic [63:0] link_data;
    fbu_state_t  state_dbg;
    logic [63:0] regs [32];

    fetch_branch_unit_if bus ();

    fetch_branch_unit dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .pc        (pc),
        .ps        (ps),
        .pc_offset (pc_offset),
        .flags     (flags),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .link_we   (link_we),
        .link_data (link_data),
        .state_dbg (state_dbg),
        .bus       (bus)
    );

    // Register file model: combinational read
    assign rf_data = regs[rf_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t exp_q [$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'b000:  r = z;
            3'b001:  r = cf;
            3'b010:  r = n;
            3'b011:  r = v;
            3'b100:  r = cf && !z;
            3'b101:  r = (n == v);
            3'b110:  r = (n == v) && !z;
            default: r = 1'b1;
        endcase
        if (c[0] && c != 4'b1111) r = !r;
        return r;
    endfunction

    // Next PC rule the PC applies to (ps, pc_offset)
    function automatic logic [63:0] pc_apply(input logic [1:0] s, input logic [63:0] off, input logic [63:0] p);
        case (s)
            2'b01:   return p + 64'd4;
            2'b10:   return off;
            2'b11:   return p + 64'd4 + (off << 2);
            default: return p;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic [63:0] pcv, input logic [3:0] f);
        exp_t        e;
        logic [63:0] imm;
        e         = '0;
        e.w       = w;
        e.pc      = pcv;
        e.ps      = 2'b01;
        e.nxt     = pcv + 64'd4;
        if (w[30:26] == 5'b00101) begin
            imm       = {{38{w[25]}}, w[25:0]};
            e.ps      = 2'b11;
            e.nxt     = pcv + imm * 64'd4;
            e.off     = imm - 64'd1;
            e.chk_off = 1'b1;
            e.link    = w[31];
        end else if (w[31:24] == 8'h54 && !w[4]) begin
            imm = {{45{w[23]}}, w[23:5]};
            if (cond_holds(w[3:0], f)) begin
                e.ps      = 2'b11;
                e.nxt     = pcv + imm * 64'd4;
                e.off     = imm - 64'd1;
                e.chk_off = 1'b1;
            end
        end else if (w[31:25] == 7'b1011010) begin
            imm  = {{45{w[23]}}, w[23:5]};
            e.ra = w[4:0];
            if ((regs[w[4:0]] == 64'd0) ^ w[24]) begin
                e.ps      = 2'b11;
                e.nxt     = pcv + imm * 64'd4;
                e.off     = imm - 64'd1;
                e.chk_off = 1'b1;
            end
        end else if (w[31:10] == 22'b1101011000011111000000 && w[4:0] == 5'd0) begin
            e.ra      = w[9:5];
            e.ps      = 2'b10;
            e.nxt     = regs[w[9:5]];
            e.off     = regs[w[9:5]];
            e.chk_off = 1'b1;
        end else begin
            e.chk_off = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 6))
            0: return {6'b000101, r[25:0]};
            1: return {6'b100101, r[25:0]};
            2: return {8'h54, r[23:5], 1'b0, r[3:0]};
            3: return {8'hB4, r[23:0]};
            4: return {8'hB5, r[23:0]};
            5: return {22'b1101011000011111000000, r[9:5], 5'd0};
            default: return r;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL accept_unexpected: got instr %h expected none", bus.instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr", bus.instr, mon_e.w);
                    check("instr_pc", bus.instr_pc, mon_e.pc);
                    check("ps", ps, mon_e.ps);
                    check("next_pc", pc_apply(ps, pc_offset, mon_e.pc), mon_e.nxt);
                    if (mon_e.chk_off) check("pc_offset", pc_offset, mon_e.off);
                    check("link_we", link_we, mon_e.link);
                    if (mon_e.link) check("link_data", link_data, mon_e.pc + 64'd4);
                    check("rf_addr", rf_addr, mon_e.ra);
                end
            end else begin
                check("ps_quiet", ps, 2'b00);
                check("link_we_quiet", link_we, 1'b0);
                check("pc_offset_quiet", pc_offset, 64'd0);
                if (bus.instr_valid) check("req_in_exec", bus.imem_req, 1'b0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_txn(input logic [31:0] w, input logic [63:0] pcv, input logic [3:0] nzcv,
                           input int ack_dly, input int rdy_dly, input bit en_after);
        int waited;
        waited          = 0;
        pc              = pcv;
        flags           = nzcv;
        enable          = 1'b1;
        bus.instr_ready = 1'b0;
        bus.imem_ack    = 1'b0;
        while (!bus.imem_req && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.imem_req) begin
            check("req_timeout", 64'd0, 64'd1);
            return;
        end
        check("imem_addr", bus.imem_addr, pcv);
        for (int d = 0; d < ack_dly; d++) begin
            tick();
            check("req_held", bus.imem_req, 1'b1);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        exp_q.push_back(model(w, pcv, nzcv));
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom();
        enable         = en_after;
        check("valid_after_ack", bus.instr_valid, 1'b1);
        check("req_after_ack", bus.imem_req, 1'b0);
        for (int d = 0; d < rdy_dly; d++) begin
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom();
            tick();
        end
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("req_after_accept", bus.imem_req, en_after);
        check("valid_after_accept", bus.instr_valid, 1'b0);
        if (!en_after) begin
            tick();
            check("idle_parked", bus.imem_req, 1'b0);
        end
    endtask

    task automatic reset_mid_req();
        tick();
        check("in_req", bus.imem_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("req_on_reset", bus.imem_req, 1'b0);
        check("valid_on_reset", bus.instr_valid, 1'b0);
        tick();
        reset          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h14000005;
        check("idle_after_reset", bus.imem_req, 1'b0);
        tick();
        bus.imem_ack = 1'b0;
        check("refetch_req", bus.imem_req, 1'b1);
        check("stale_ack_ignored", bus.instr_valid, 1'b0);
        tick();
        check("still_req", bus.imem_req, 1'b1);
        check("still_no_valid", bus.instr_valid, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    logic [63:0] next_pc;
    exp_t        tmp_e;
    logic [31:0] w;
    logic [3:0]  f;

    initial begin
        reset           = 1'b1;
        enable          = 1'b1;
        pc              = 64'd0;
        flags           = 4'd0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 64'd0;
        tick();
        tick();
        check("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_ps", ps, 2'b00);
        check("rst_pc_offset", pc_offset, 64'd0);
        check("rst_instr_valid", bus.instr_valid, 1'b0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_instr_pc", bus.instr_pc, 64'd0);
        check("rst_link_we", link_we, 1'b0);
        check("rst_link_data", link_data, 64'd0);
        check("rst_rf_addr", rf_addr, 5'd0);
        reset = 1'b0;
        check("req_low_after_release", bus.imem_req, 1'b0);
        tick();
        check("first_req", bus.imem_req, 1'b1);

        // Directed cases
        run_txn(32'h8B020020, 64'h0,   4'b0000, 2, 0, 1'b1);
        run_txn(32'h14000003, 64'h100, 4'b0000, 0, 0, 1'b1);
        run_txn(32'h14000000, 64'h100, 4'b0000, 0, 0, 1'b1);
        run_txn(32'h54FFFFC0, 64'h200, 4'b0100, 0, 0, 1'b1);
        run_txn(32'h54FFFFC0, 64'h200, 4'b0000, 1, 0, 1'b1);
        regs[3] = 64'd0;
        run_txn(32'hB4000083, 64'h300, 4'b0000, 0, 1, 1'b1);
        regs[3] = 64'd5;
        run_txn(32'hB4000083, 64'h300, 4'b0000, 0, 0, 1'b1);
        run_txn(32'hB5000083, 64'h300, 4'b0000, 0, 0, 1'b1);
        regs[7] = 64'h2000;
        run_txn(32'hD61F00E0, 64'h400, 4'b0000, 0, 0, 1'b1);
        run_txn(32'h94000001, 64'h40,  4'b0000, 0, 0, 1'b1);
        run_txn(32'h8B020020, 64'h44,  4'b0000, 0, 3, 1'b0);
        run_txn(32'h14000002, 64'h48,  4'b0000, 1, 2, 1'b1);
        reset_mid_req();
        run_txn(32'h54000021, 64'h500, 4'b0100, 0, 0, 1'b1);

        // Random streams following the modelled control flow
        next_pc = 64'h1000;
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 32; i++)
                regs[i] = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) next_pc = {$urandom(), $urandom()} & ~64'd3;
            w     = gen_instr();
            f     = 4'($urandom_range(0, 15));
            tmp_e = model(w, next_pc, f);
            run_txn(w, next_pc, f, $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 3) != 0));
            next_pc = tmp_e.nxt;
        end

        tick();
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
